// File: rtl/fp_mult_scheduler.sv
// fp_mult_scheduler
// Round-robin scheduler that time-shares one multi-cycle floating-point
// multiplier among NUM_REQ requesters and returns the product tagged with the
// requester index.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      per-requester request and one-hot grant
//   req_a, req_b               packed operands, requester i at [32i+31:32i]
//   resp_valid / resp_ready    response handshake
//   resp_id, resp_result       served requester and its product
//   resp_exception/overflow/underflow  multiplier flags, passed through as-is
//   busy                       high in every state except IDLE
//   mult_a, mult_b, mult_reset operands and load/start strobe to the multiplier
//   mult_result, mult_*        product and flags from the multiplier
//
// state | meaning
// IDLE  | waiting for a request; issues at most one grant per visit
// LOAD  | mult_reset held high for START_CYCLES cycles to load operands
// RUN   | counting MULT_LATENCY cycles until the product is valid
// RESP  | captured result presented until resp_ready
module fp_mult_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int START_CYCLES = 2,
  parameter int MULT_LATENCY = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  resp_exception,
  output logic                  resp_overflow,
  output logic                  resp_underflow,
  output logic                  busy,
  output logic [31:0]           mult_a,
  output logic [31:0]           mult_b,
  output logic                  mult_reset,
  input  logic [31:0]           mult_result,
  input  logic                  mult_exception,
  input  logic                  mult_overflow,
  input  logic                  mult_underflow
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] grant_id;
  logic            grant_found;
  logic [7:0]      cnt;
  logic            load_done;
  logic            run_done;
  logic [31:0]     a_arr [NUM_REQ];
  logic [31:0]     b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[32*gi +: 32];
    assign b_arr[gi] = req_b[32*gi +: 32];
  end

  assign load_done = (cnt == 8'(START_CYCLES - 1));
  assign run_done  = (cnt == 8'(MULT_LATENCY - 1));

  // First set request at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin : grant_search
    int              idx;
    logic [ID_W-1:0] idx_t;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_t       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = ID_W'(idx);
      if (!grant_found && req_valid[idx_t]) begin
        grant_found = 1'b1;
        grant_id    = idx_t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    busy       = 1'b1;
    mult_reset = reset;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_found && !reset) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = LOAD;
        end
      end
      LOAD: begin
        mult_reset = 1'b1;
        if (load_done) state_nxt = RUN;
      end
      RUN:  if (run_done) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      id_reg         <= '0;
      cnt            <= '0;
      mult_a         <= '0;
      mult_b         <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_result    <= '0;
      resp_exception <= 1'b0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            mult_a <= a_arr[grant_id];
            mult_b <= b_arr[grant_id];
            id_reg <= grant_id;
            cnt    <= '0;
            if (grant_id == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                                rr_ptr <= grant_id + 1'b1;
          end
        end
        LOAD: begin
          if (load_done) cnt <= '0;
          else           cnt <= cnt + 1'b1;
        end
        RUN: begin
          if (run_done) begin
            resp_valid     <= 1'b1;
            resp_id        <= id_reg;
            resp_result    <= mult_result;
            resp_exception <= mult_exception;
            resp_overflow  <= mult_overflow;
            resp_underflow <= mult_underflow;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_scheduler.sv
// tb_fp_mult_scheduler
// Self-checking bench for fp_mult_scheduler. A behavioural multiplier drives
// garbage until its latency has elapsed after mult_reset falls; a scoreboard
// records the expected tagged result at each grant and checks it on handshake.
module tb_fp_mult_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int START   = 2;
  localparam int LAT     = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_exception;
  logic                  resp_overflow;
  logic                  resp_underflow;
  logic                  busy;
  logic [31:0]           mult_a;
  logic [31:0]           mult_b;
  logic                  mult_reset;
  logic [31:0]           mult_result;
  logic                  mult_exception;
  logic                  mult_overflow;
  logic                  mult_underflow;

  fp_mult_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .START_CYCLES(START), .MULT_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_exception(resp_exception), .resp_overflow(resp_overflow),
    .resp_underflow(resp_underflow), .busy(busy),
    .mult_a(mult_a), .mult_b(mult_b), .mult_reset(mult_reset),
    .mult_result(mult_result), .mult_exception(mult_exception),
    .mult_overflow(mult_overflow), .mult_underflow(mult_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-precision multiply: RNE, denormal inputs as zero,
  // returns {exception, overflow, underflow, result}.
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    logic        g;
    logic        st;
    logic [23:0] mr;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, 32'h7FC00000};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {3'b000, 32'h0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m = p[46:24]; g = p[23]; st = |p[22:0];
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    mr = {1'b0, m};
    if (g && (st || m[0])) mr = mr + 24'd1;
    if (mr[23]) e++;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, 32'h0};
    return {3'b000, s, e[7:0], mr[22:0]};
  endfunction

  int          mcnt = 0;
  logic [34:0] mmod;
  logic        mvalid;
  always @(posedge clk) begin
    if (mult_reset)       mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end
  assign mmod           = fmul(mult_a, mult_b);
  assign mvalid         = (mcnt >= LAT - 1);
  assign mult_result    = mvalid ? mmod[31:0] : 32'hBAD0BAD0;
  assign mult_exception = mvalid ? mmod[34] : 1'b1;
  assign mult_overflow  = mvalid ? mmod[33] : 1'b1;
  assign mult_underflow = mvalid ? mmod[32] : 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    logic [2:0]      flg;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_res [NUM_REQ];
  logic [2:0]  cur_flg [NUM_REQ];
  int          grant_cyc = 0;
  int          hs_cyc    = 0;
  int          run_len   = 0;
  int          mon_g     = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_res   = '0;
  logic [ID_W-1:0] prev_id = '0;
  logic [2:0]  prev_flg   = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      run_len    = 0;
    end else begin
      if (req_ready != '0) begin
        check("grant_legal",
              32'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) mon_g = i;
        sb.push_back('{id: ID_W'(mon_g), res: cur_res[mon_g], flg: cur_flg[mon_g]});
        grant_cyc = cyc;
      end
      if (resp_valid) check("ready_in_resp", 32'(req_ready), 32'd0);
      if (resp_valid && !prev_valid)
        check("latency", 32'(cyc - grant_cyc), 32'(START + LAT + 1));
      if (resp_valid && prev_valid && !prev_ready) begin
        check("hold_result", resp_result, prev_res);
        check("hold_id", 32'(resp_id), 32'(prev_id));
        check("hold_flags", 32'({resp_exception, resp_overflow, resp_underflow}), 32'(prev_flg));
      end
      if (resp_valid && resp_ready) begin
        hs_cyc = cyc;
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id", 32'(resp_id), 32'(e.id));
          check("resp_result", resp_result, e.res);
          check("resp_flags", 32'({resp_exception, resp_overflow, resp_underflow}), 32'(e.flg));
        end
      end
      if (mult_reset) run_len++;
      else if (run_len != 0) begin
        check("start_len", 32'(run_len), 32'(START));
        run_len = 0;
      end
      prev_valid = resp_valid;
      prev_ready = resp_ready;
      prev_res   = resp_result;
      prev_id    = resp_id;
      prev_flg   = {resp_exception, resp_overflow, resp_underflow};
    end
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] flg);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    cur_res[id]        = res;
    cur_flg[id]        = flg;
    req_valid[id]      = 1'b1;
  endtask

  task automatic wait_grant(input int id, output int gc);
    gc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        gc = cyc;
        break;
      end
    end
    check("grant_seen", 32'(gc >= 0), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_any(output int g, output int gc);
    g  = -1;
    gc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gc = cyc;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        break;
      end
    end
    check("any_grant_seen", 32'(gc >= 0), 32'd1);
  endtask

  task automatic drain();
    int done;
    done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    check("drain", 32'(done), 32'd1);
  endtask

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  int   rr_order [5];

  initial begin
    int gc;
    int g;

    vecs[0] = '{0, 32'h49072340, 32'h44520000, 32'h4DDDB5D5, 3'b000};
    vecs[1] = '{2, 32'h3F800000, 32'h4EA0C8E4, 32'h4EA0C8E4, 3'b000};
    vecs[2] = '{1, 32'h00000000, 32'hCE8EF06B, 32'h00000000, 3'b000};
    vecs[3] = '{3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
    vecs[4] = '{0, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
    vecs[5] = '{1, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b100};
    vecs[6] = '{3, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000};
    rr_order = '{0, 1, 2, 3, 0};

    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_res[i] = '0;
      cur_flg[i] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_flags", 32'({resp_exception, resp_overflow, resp_underflow}), 32'd0);
    check("rst_mult_a", mult_a, 32'd0);
    check("rst_mult_b", mult_b, 32'd0);
    check("rst_mult_reset", 32'(mult_reset), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_mult_reset", 32'(mult_reset), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      set_req(vecs[k].req, vecs[k].a, vecs[k].b, vecs[k].res, vecs[k].flg);
      wait_grant(vecs[k].req, gc);
      check("operand_a", mult_a, vecs[k].a);
      check("operand_b", mult_b, vecs[k].b);
      drain();
    end

    // All requesters continuously valid.
    @(posedge clk); #1;
    set_req(0, 32'hC3818000, 32'hC3818000, 32'h47830480, 3'b000);
    set_req(1, 32'h3F800000, 32'h40490FDB, 32'h40490FDB, 3'b000);
    set_req(2, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    set_req(3, 32'h49072340, 32'h44520000, 32'h4DDDB5D5, 3'b000);
    for (int k = 0; k < 5; k++) begin
      wait_any(g, gc);
      check("rr_order", 32'(g), 32'(rr_order[k]));
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure with a second requester waiting.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    set_req(1, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    wait_grant(1, gc);
    set_req(3, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    gc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        gc = cyc;
        break;
      end
    end
    check("bp_resp_valid", 32'(gc >= 0), 32'd1);
    repeat (10) @(negedge clk);
    check("bp_still_valid", 32'(resp_valid), 32'd1);
    check("bp_result", resp_result, 32'h40C00000);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_grant(3, gc);
    check("grant_after_hs", 32'(gc), 32'(hs_cyc + 1));
    drain();

    // Reset in the middle of RUN, then confirm rr_ptr returned to 0.
    @(posedge clk); #1;
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    wait_grant(1, gc);
    repeat (12) @(posedge clk);
    #1;
    check("run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_mult_reset", 32'(mult_reset), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    set_req(0, 32'h49072340, 32'h44520000, 32'h4DDDB5D5, 3'b000);
    set_req(3, 32'h3F800000, 32'h4EA0C8E4, 32'h4EA0C8E4, 3'b000);
    wait_any(g, gc);
    check("post_rst_grant", 32'(g), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_grant(3, gc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_mult_scheduler.md
Name: fp_mult_scheduler

Overview:
- Round-robin scheduler that shares one multi-cycle integrationMult floating-point multiplier among NUM_REQ requesters.
- Grants one request at a time, latches its operands, and pulses the multiplier's reset/start input.
- Waits the fixed multiplier latency, captures result and flags, and returns them tagged with the requester ID over a valid/ready response port.
- Sits between the requesting datapaths and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- START_CYCLES, 2, cycles mult_reset is held high to load operands (1..15).
- MULT_LATENCY, 32, cycles after mult_reset falls until mult_result is valid (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant; operands accepted this cycle.
- req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B; same packing as req_a.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  ID_W  index of the served requester.
- resp_result  out  32  product, IEEE-754 single.
- resp_exception  out  1  captured multiplier exception flag.
- resp_overflow  out  1  captured multiplier overflow flag.
- resp_underflow  out  1  captured multiplier underflow flag.
- busy  out  1  high in every state except IDLE.
- mult_a  out  32  operand A to the multiplier.
- mult_b  out  32  operand B to the multiplier.
- mult_reset  out  1  multiplier reset/start.
- mult_result  in  32  multiplier result.
- mult_exception  in  1  multiplier exception flag.
- mult_overflow  in  1  multiplier overflow flag.
- mult_underflow  in  1  multiplier underflow flag.

Behaviour:
- Reset state: FSM=IDLE; rr_ptr=0 (requester 0 has highest priority); cnt=0.
- Reset values: all resp_* outputs=0, busy=0, mult_a=mult_b=0.
- mult_reset = reset OR (state==LOAD).
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req_valid bit is set, select grant g = first set bit searching from rr_ptr upward, wrapping at NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle only; all other req_ready bits are 0.
  - On the clock edge: latch req_a[g] and req_b[g] into mult_a and mult_b; set id_reg=g; set rr_ptr=(g+1) mod NUM_REQ; clear cnt; go to LOAD.
  - If no req_valid bit is set: stay in IDLE; req_ready=0.
- LOAD: mult_reset=1 for exactly START_CYCLES cycles, then go to RUN with cnt cleared.
- RUN:
  - mult_reset=0; cnt increments each cycle.
  - When cnt==MULT_LATENCY-1: capture mult_result and the three flags into resp_*; set resp_id=id_reg; go to RESP.
- RESP:
  - resp_valid=1; all resp_* outputs are held stable while resp_ready=0.
  - On resp_valid & resp_ready: clear resp_valid and go to IDLE.
  - No new grant is issued in the same cycle as the handshake.
- mult_a and mult_b are stable from the cycle after grant until the next grant.
- req_ready is always 0 outside IDLE, so requests are never lost; a requester keeps req_valid high until it is granted.
- Latency: grant in cycle 0 -> resp_valid first high in cycle START_CYCLES+MULT_LATENCY+1 (35 with defaults).
- Throughput: one operation per START_CYCLES+MULT_LATENCY+2 cycles when resp_ready is held high.
- Fairness: with all requesters continuously valid, grants follow 0,1,2,3,0,...
- Dropping req_valid after grant has no effect; operands are already latched.
- Synchronous reset mid-operation: FSM returns to IDLE, any in-flight result is discarded, resp_valid=0 next cycle, rr_ptr=0.
- Flags are passed through unmodified; the scheduler does not interpret overflow or underflow.

Test Plan:
- Single request: req0 with a=0x49072340, b=0x44520000 -> req_ready=0001 for one cycle; resp_valid rises 35 cycles later with resp_id=0, resp_result=0x4DDDB5D5, all flags 0.
- Identity: req2 with a=0x3F800000, b=0x4EA0C8E4 -> resp_id=2, resp_result=0x4EA0C8E4; mult_reset high for exactly 2 cycles.
- Round robin: all 4 requesters held valid with distinct operands; resp_ready=1 -> resp_id sequence 0,1,2,3,0; each response matches its own operands (e.g. 0xC3818000*0xC3818000=0x47830480).
- Backpressure: resp_ready=0 for 10 cycles while resp_valid=1 -> result, id and flags held stable, req_ready stays 0; the following grant occurs the cycle after the handshake.
- Zero operand: a=0x00000000, b=0xCE8EF06B -> resp_result=0x00000000.
- Reset during RUN: assert reset at cycle 10 of RUN -> next cycle busy=0, resp_valid=0; a new request from requester 0 is served correctly.
